// File: rtl/fm7_bus_pkg.sv
// fm7_bus_pkg
//   Shared types and constants for the FM-7 chip-select sequencer.
//   - fm7_state_t : access sequencer states (IDLE / WAIT / DONE)
//   - FM7_SEL_W, FM7_WAIT_W : default select and wait-counter widths
//   - fm7_num_cs() : number of chip-select outputs for a given select width
package fm7_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } fm7_state_t;

  localparam int FM7_SEL_W  = 3;
  localparam int FM7_WAIT_W = 2;

  function automatic int fm7_num_cs(input int sel_w);
    return 1 << sel_w;
  endfunction

  localparam int FM7_N = fm7_num_cs(FM7_SEL_W);

endpackage

// File: rtl/fm7_wait_counter.sv
// fm7_wait_counter
//   Wait-state down-counter: loads a count, decrements while enabled and
//   saturates at zero.
// Ports
//   clk       in   system clock
//   rst_n     in   asynchronous active-low reset (count -> 0)
//   load      in   load load_val this cycle (has priority over dec)
//   load_val  in   WAIT_W   value to load
//   dec       in   decrement by one this cycle (never below zero)
//   zero_next out  count reaches zero at the end of this decrementing cycle
module fm7_wait_counter #(
  parameter int WAIT_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [WAIT_W-1:0] load_val,
  input  logic              dec,
  output logic              zero_next
);

  logic [WAIT_W-1:0] cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= load_val;
    end else if (dec && (cnt_reg != '0)) begin
      cnt_reg <= cnt_reg - 1'b1;
    end
  end

  // A count of 1 (or 0) means this is the last wait cycle.
  assign zero_next = (cnt_reg <= WAIT_W'(1));

endmodule

// File: rtl/fm7_cs_sequencer.sv
// fm7_cs_sequencer
//   '138-style decoder with per-output wait states. A req with the three
//   enables true latches sel, drives the selected chip select low for
//   wait_cfg[sel]+1 cycles and pulses ready on the last of them. A req with
//   the enables false produces a ready+miss pulse and no select.
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   g1, g2a_n, g2b_n      '138 enables (G1 high, G2A/G2B low)
//   sel      [SEL_W]      output index (sel[0] = A)
//   req                   one-cycle access request
//   wait_cfg [N*WAIT_W]   wait count of output i at [i*WAIT_W +: WAIT_W]
//   y_n      [N]          registered active-low chip selects
//   ready                 one-cycle access-complete pulse
//   miss                  with ready: request had enables false
//   busy                  access in progress
//   overrun               sticky: req seen while busy
module fm7_cs_sequencer
  import fm7_bus_pkg::*;
#(
  parameter int SEL_W  = FM7_SEL_W,
  parameter int WAIT_W = FM7_WAIT_W,
  localparam int N     = fm7_num_cs(SEL_W)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                g1,
  input  logic                g2a_n,
  input  logic                g2b_n,
  input  logic [SEL_W-1:0]    sel,
  input  logic                req,
  input  logic [N*WAIT_W-1:0] wait_cfg,
  output logic [N-1:0]        y_n,
  output logic                ready,
  output logic                miss,
  output logic                busy,
  output logic                overrun
);

  fm7_state_t        state_reg;
  logic [SEL_W-1:0]  idx_reg;
  logic [N-1:0]      y_n_reg;
  logic              ready_reg;
  logic              miss_reg;
  logic              busy_reg;
  logic              overrun_reg;

  logic [WAIT_W-1:0] wait_arr [N];
  logic [WAIT_W-1:0] sel_wait;
  logic              en;
  logic              accept;
  logic              zero_next;

  for (genvar gi = 0; gi < N; gi++) begin : g_wait_slice
    assign wait_arr[gi] = wait_cfg[gi*WAIT_W +: WAIT_W];
  end

  assign en       = g1 & ~g2a_n & ~g2b_n;
  assign sel_wait = wait_arr[sel];
  assign accept   = (state_reg == IDLE) && req && en;

  function automatic logic [N-1:0] cs_decode(input logic [SEL_W-1:0] s);
    logic [N-1:0] v;
    v    = '1;
    v[s] = 1'b0;
    return v;
  endfunction

  // The counter is loaded on the accept edge, so it holds the full wait
  // count during the first WAIT cycle.
  fm7_wait_counter #(
    .WAIT_W (WAIT_W)
  ) u_wait_counter (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (accept),
    .load_val  (sel_wait),
    .dec       (state_reg == WAIT),
    .zero_next (zero_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      idx_reg     <= '0;
      y_n_reg     <= '1;
      ready_reg   <= 1'b0;
      miss_reg    <= 1'b0;
      busy_reg    <= 1'b0;
      overrun_reg <= 1'b0;
    end else begin
      ready_reg <= 1'b0;
      miss_reg  <= 1'b0;
      case (state_reg)
        IDLE: begin
          y_n_reg  <= '1;
          busy_reg <= 1'b0;
          if (req && en) begin
            idx_reg  <= sel;
            y_n_reg  <= cs_decode(sel);
            busy_reg <= 1'b1;
            if (sel_wait != '0) begin
              state_reg <= WAIT;
            end else begin
              // Zero wait: select and ready appear together.
              state_reg <= DONE;
              ready_reg <= 1'b1;
            end
          end else if (req) begin
            ready_reg <= 1'b1;
            miss_reg  <= 1'b1;
          end
        end
        WAIT: begin
          y_n_reg <= cs_decode(idx_reg);
          if (req) overrun_reg <= 1'b1;
          if (zero_next) begin
            state_reg <= DONE;
            ready_reg <= 1'b1;
          end
        end
        DONE: begin
          // A req here is refused, guaranteeing an all-high gap cycle.
          if (req) overrun_reg <= 1'b1;
          state_reg <= IDLE;
          y_n_reg   <= '1;
          busy_reg  <= 1'b0;
        end
        default: begin
          state_reg <= IDLE;
          y_n_reg   <= '1;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign y_n     = y_n_reg;
  assign ready   = ready_reg;
  assign miss    = miss_reg;
  assign busy    = busy_reg;
  assign overrun = overrun_reg;

endmodule

// File: tb/tb_fm7_cs_sequencer.sv
// tb_fm7_cs_sequencer
//   Directed and randomized bench for fm7_cs_sequencer. The reference model
//   records each access as a cycle interval [start, end] plus a miss cycle
//   and a sticky overrun bit, and derives the expected outputs of every
//   cycle from those intervals.
module tb_fm7_cs_sequencer;

  localparam int SEL_W  = 3;
  localparam int WAIT_W = 2;
  localparam int N      = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          g1, g2a_n, g2b_n;
  logic [2:0]    sel;
  logic          req;
  logic [15:0]   wait_cfg;
  logic [7:0]    y_n;
  logic          ready, miss, busy, overrun;

  always #5 clk = ~clk;

  fm7_cs_sequencer #(
    .SEL_W  (SEL_W),
    .WAIT_W (WAIT_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .g1       (g1),
    .g2a_n    (g2a_n),
    .g2b_n    (g2b_n),
    .sel      (sel),
    .req      (req),
    .wait_cfg (wait_cfg),
    .y_n      (y_n),
    .ready    (ready),
    .miss     (miss),
    .busy     (busy),
    .overrun  (overrun)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Reference model state
  bit act_valid = 1'b0;
  int act_start = 0;
  int act_end   = 0;
  int act_idx   = 0;
  int miss_cyc  = -10;
  bit ov_exp    = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
  endtask

  function automatic bit m_busy(input int c);
    return act_valid && (c >= act_start) && (c <= act_end);
  endfunction

  task automatic check_outputs();
    logic [7:0] ey;
    bit         er;
    ey = 8'hFF;
    if (m_busy(cyc)) ey[act_idx] = 1'b0;
    er = (m_busy(cyc) && (cyc == act_end)) || (cyc == miss_cyc);
    check_eq("y_n",     32'(y_n),     32'(ey));
    check_eq("busy",    32'(busy),    32'(m_busy(cyc)));
    check_eq("ready",   32'(ready),   32'(er));
    check_eq("miss",    32'(miss),    32'(cyc == miss_cyc));
    check_eq("overrun", 32'(overrun), 32'(ov_exp));
  endtask

  // Drive one cycle of inputs, update the model, advance a clock, check.
  task automatic tick(input bit r, input bit a, input bit b, input bit c,
                      input logic [2:0] s, input logic [15:0] wc);
    int si;
    int w;
    bit e;
    bit ov_next;
    g1 = a; g2a_n = b; g2b_n = c; sel = s; wait_cfg = wc; req = r;
    si = int'(s);
    w  = int'((wc >> (si * 2)) & 16'h3);
    e  = a & !b & !c;
    ov_next = ov_exp;
    if (r) begin
      if (m_busy(cyc)) begin
        ov_next = 1'b1;
        $display("cyc %0d: req sel=%0d ignored while busy -> overrun", cyc, si);
      end else if (e) begin
        act_valid = 1'b1;
        act_start = cyc + 1;
        act_end   = cyc + 1 + w;
        act_idx   = si;
        $display("cyc %0d: req sel=%0d wait=%0d -> select %0d..%0d", cyc, si, w, act_start, act_end);
      end else begin
        miss_cyc = cyc + 1;
        $display("cyc %0d: req sel=%0d disabled (g1=%0b g2a_n=%0b g2b_n=%0b) -> miss", cyc, si, a, b, c);
      end
    end
    @(posedge clk);
    cyc++;
    ov_exp = ov_next;
    #1;
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      tick(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 3'($urandom), 16'($urandom));
  endtask

  initial begin
    rst_n = 1'b0; g1 = 1'b0; g2a_n = 1'b1; g2b_n = 1'b1;
    sel = '0; req = 1'b0; wait_cfg = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_y_n",     32'(y_n),     32'h0000_00FF);
    check_eq("rst_busy",    32'(busy),    32'h0);
    check_eq("rst_ready",   32'(ready),   32'h0);
    check_eq("rst_overrun", 32'(overrun), 32'h0);
    #1 rst_n = 1'b1;
    cyc = 0;
    idle(2);

    // Zero wait on output 5
    tick(1'b1, 1'b1, 1'b0, 1'b0, 3'd5, 16'h0000);
    check_eq("zw_y_n", 32'(y_n), 32'h0000_00DF);
    check_eq("zw_ready", 32'(ready), 32'h1);
    idle(1);
    check_eq("zw_gap", 32'(y_n), 32'h0000_00FF);
    idle(1);

    // Maximum wait on output 2
    tick(1'b1, 1'b1, 1'b0, 1'b0, 3'd2, 16'h0030);
    check_eq("mw_y_n", 32'(y_n), 32'h0000_00FB);
    idle(3);
    check_eq("mw_ready", 32'(ready), 32'h1);
    idle(1);
    check_eq("mw_busy", 32'(busy), 32'h0);
    idle(1);

    // Disabled request
    tick(1'b1, 1'b1, 1'b1, 1'b0, 3'd3, 16'hFFFF);
    check_eq("dis_y_n", 32'(y_n), 32'h0000_00FF);
    check_eq("dis_miss", 32'(miss), 32'h1);
    idle(1);

    // Overrun during WAIT of output 1
    tick(1'b1, 1'b1, 1'b0, 1'b0, 3'd1, 16'h0008);
    tick(1'b1, 1'b1, 1'b0, 1'b0, 3'd6, 16'h0000);
    idle(3);
    check_eq("ov_sticky", 32'(overrun), 32'h1);

    // Reset mid-WAIT
    tick(1'b1, 1'b1, 1'b0, 1'b0, 3'd2, 16'h0030);
    idle(1);
    #1 rst_n = 1'b0;
    #1;
    check_eq("arst_y_n",    32'(y_n),     32'h0000_00FF);
    check_eq("arst_busy",   32'(busy),    32'h0);
    check_eq("arst_ready",  32'(ready),   32'h0);
    check_eq("arst_ovr",    32'(overrun), 32'h0);
    @(posedge clk);
    cyc++;
    #2 rst_n = 1'b1;
    act_valid = 1'b0; miss_cyc = -10; ov_exp = 1'b0;
    idle(6);

    // Sweep all outputs with random waits and enable combinations
    for (int s = 0; s < N; s++) begin
      tick(1'b1, ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 3) == 0), 3'(s), 16'($urandom));
      idle(5);
    end

    // Random traffic
    for (int i = 0; i < 800; i++) begin
      tick(($urandom_range(0, 2) == 0), ($urandom_range(0, 5) != 0),
           ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0),
           3'($urandom), 16'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
